// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded instruction for EX, inserts a
// one-cycle bubble on load-use hazards and squashes the slot on an EX redirect.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [2:0]            id_funct3,
    input  logic [6:0]            id_funct7,
    input  logic [10:0]           id_ctrl,
    input  logic                  flush_i,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [2:0]            ex_funct3,
    output logic [6:0]            ex_funct7,
    output logic [10:0]           ex_ctrl,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // Position of MemRead inside the {ALUSrc,MemtoReg,RegWrite,MemRead,...} bundle.
    localparam int MEM_READ_BIT = 7;

    logic                  ex_valid_r;
    logic [DATA_W-1:0]     ex_pc_r;
    logic [DATA_W-1:0]     ex_rd1_r;
    logic [DATA_W-1:0]     ex_rd2_r;
    logic [DATA_W-1:0]     ex_imm_r;
    logic [REG_ADDR_W-1:0] ex_rs1_r;
    logic [REG_ADDR_W-1:0] ex_rs2_r;
    logic [REG_ADDR_W-1:0] ex_rd_r;
    logic [2:0]            ex_funct3_r;
    logic [6:0]            ex_funct7_r;
    logic [10:0]           ex_ctrl_r;
    logic [CNT_W-1:0]      bubble_cnt_r;
    logic [CNT_W-1:0]      flush_cnt_r;
    logic                  haz_s;
    logic                  stall_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Load-use detection against the instruction currently in EX.
    always_comb begin
        haz_s   = 1'b0;
        stall_s = 1'b0;
        if (id_valid && ex_valid_r && ex_ctrl_r[MEM_READ_BIT] &&
            (ex_rd_r != {REG_ADDR_W{1'b0}}) &&
            ((ex_rd_r == id_rs1) || (ex_rd_r == id_rs2))) begin
            haz_s = 1'b1;
        end else begin
            haz_s = 1'b0;
        end
        // A redirect discards the ID instruction, so holding it would be pointless.
        if (haz_s && !flush_i) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Pipeline register: flush beats bubble beats normal capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r  <= 1'b0;
            ex_pc_r     <= {DATA_W{1'b0}};
            ex_rd1_r    <= {DATA_W{1'b0}};
            ex_rd2_r    <= {DATA_W{1'b0}};
            ex_imm_r    <= {DATA_W{1'b0}};
            ex_rs1_r    <= {REG_ADDR_W{1'b0}};
            ex_rs2_r    <= {REG_ADDR_W{1'b0}};
            ex_rd_r     <= {REG_ADDR_W{1'b0}};
            ex_funct3_r <= 3'b000;
            ex_funct7_r <= 7'b0000000;
            ex_ctrl_r   <= 11'b0;
        end else if (flush_i || haz_s) begin
            // Data fields keep their old values; only valid/ctrl must be cleared.
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= 11'b0;
        end else begin
            ex_valid_r  <= id_valid;
            ex_pc_r     <= id_pc;
            ex_rd1_r    <= id_rd1;
            ex_rd2_r    <= id_rd2;
            ex_imm_r    <= id_imm;
            ex_rs1_r    <= id_rs1;
            ex_rs2_r    <= id_rs2;
            ex_rd_r     <= id_rd;
            ex_funct3_r <= id_funct3;
            ex_funct7_r <= id_funct7;
            ex_ctrl_r   <= id_valid ? id_ctrl : 11'b0;
        end
    end

    // Saturating performance counters for bubbles and squashed instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            if (id_valid) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end else if (haz_s) begin
            bubble_cnt_r <= sat_inc(bubble_cnt_r);
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
            flush_cnt_r  <= flush_cnt_r;
        end
    end

    assign ex_valid   = ex_valid_r;
    assign ex_pc      = ex_pc_r;
    assign ex_rd1     = ex_rd1_r;
    assign ex_rd2     = ex_rd2_r;
    assign ex_imm     = ex_imm_r;
    assign ex_rs1     = ex_rs1_r;
    assign ex_rs2     = ex_rs2_r;
    assign ex_rd      = ex_rd_r;
    assign ex_funct3  = ex_funct3_r;
    assign ex_funct7  = ex_funct7_r;
    assign ex_ctrl    = ex_ctrl_r;
    assign stall_o    = stall_s;
    assign bubble_cnt = bubble_cnt_r;
    assign flush_cnt  = flush_cnt_r;

endmodule
